// File: rtl/tof_i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master among N_REQ ToF sensor FSMs.
// Bursts keep the grant, and a watchdog reclaims a stalled grant and flags the owner.
module tof_i2c_arbiter #(
  parameter int N_REQ       = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_start,
  input  logic [N_REQ-1:0]      req_is_read,
  input  logic [N_REQ-1:0]      req_nb_of_bytes,
  input  logic [N_REQ*16-1:0]   req_register_address,
  input  logic [N_REQ*8-1:0]    req_i2c_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [7:0]            req_data_in,
  output logic [N_REQ-1:0]      req_error,
  output logic                  m_start,
  output logic                  m_is_read,
  output logic                  m_nb_of_bytes,
  output logic [15:0]           m_register_address,
  output logic [7:0]            m_i2c_data,
  input  logic                  m_ready,
  input  logic [7:0]            m_data_in,
  output logic                  grant_valid,
  output logic [IDX_W-1:0]      grant_idx
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, pick, scan_idx;
  logic             pick_vld;
  logic [WD_W-1:0]  wdog;
  logic             g_start, g_nb, timeout, release_ok;

  assign g_start     = req_start[grant_idx];
  assign g_nb        = req_nb_of_bytes[grant_idx];
  assign timeout     = (state == BUSY) && !m_ready && (wdog == WD_MAX);
  assign release_ok  = m_ready && !g_start && !g_nb;
  assign req_data_in = m_data_in;

  // Scan starts just past the last owner, so it ends up with lowest priority.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    scan_idx = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (scan_idx == IDX_W'(N_REQ - 1)) ? '0 : scan_idx + 1'b1;
      if (!pick_vld && req_start[scan_idx]) begin
        pick_vld = 1'b1;
        pick     = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = BUSY;
      BUSY:    if (timeout || release_ok) state_nxt = RELEASE;
      RELEASE: if (!m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      rr_ptr      <= IDX_W'(N_REQ - 1);
      wdog        <= '0;
      req_error   <= '0;
    end else begin
      req_error <= '0;
      if (state == IDLE && pick_vld) begin
        grant_idx   <= pick;
        grant_valid <= 1'b1;
      end
      if (state == RELEASE && !m_ready) begin
        rr_ptr      <= grant_idx;
        grant_valid <= 1'b0;
      end
      if (timeout) req_error[grant_idx] <= 1'b1;
      // Saturates at the firing threshold; only stalled BUSY cycles count.
      if (state != BUSY || m_ready) wdog <= '0;
      else if (wdog != WD_MAX)      wdog <= wdog + 1'b1;
    end
  end

  always_comb begin
    m_start            = 1'b0;
    m_is_read          = 1'b0;
    m_nb_of_bytes      = 1'b0;
    m_register_address = '0;
    m_i2c_data         = '0;
    req_ready          = '0;
    if (state == BUSY) begin
      m_start            = g_start;
      m_is_read          = req_is_read[grant_idx];
      m_nb_of_bytes      = g_nb;
      m_register_address = req_register_address[{grant_idx, 4'h0} +: 16];
      m_i2c_data         = req_i2c_data[{grant_idx, 3'h0} +: 8];
    end
    if (state == BUSY || state == RELEASE) req_ready[grant_idx] = m_ready;
  end

endmodule

// File: tb/tb_tof_i2c_arbiter.sv
// Directed bench for tof_i2c_arbiter: single request, rotation, burst lock,
// fairness, watchdog and asynchronous reset.
module tb_tof_i2c_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_start = '0, req_is_read = '0, req_nb_of_bytes = '0;
  logic [63:0] req_register_address = '0;
  logic [31:0] req_i2c_data = '0;
  logic [3:0]  req_ready, req_error;
  logic [7:0]  req_data_in;
  logic        m_start, m_is_read, m_nb_of_bytes;
  logic [15:0] m_register_address;
  logic [7:0]  m_i2c_data;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data_in = '0;
  logic        grant_valid;
  logic [1:0]  grant_idx;

  int checks = 0, failures = 0;

  tof_i2c_arbiter #(.N_REQ(4), .IDX_W(2), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset),
    .req_start(req_start), .req_is_read(req_is_read), .req_nb_of_bytes(req_nb_of_bytes),
    .req_register_address(req_register_address), .req_i2c_data(req_i2c_data),
    .req_ready(req_ready), .req_data_in(req_data_in), .req_error(req_error),
    .m_start(m_start), .m_is_read(m_is_read), .m_nb_of_bytes(m_nb_of_bytes),
    .m_register_address(m_register_address), .m_i2c_data(m_i2c_data),
    .m_ready(m_ready), .m_data_in(m_data_in),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic expect_grant(input int i);
    cyc(); #1;
    chk("grant_valid", grant_valid, 1);
    chk("grant_idx", grant_idx, i);
    chk("m_start", m_start, 1);
    chk("ready_before_m_ready", req_ready, 0);
  endtask

  // Owner sees ready with data, drops start; master then lowers ready.
  task automatic finish_txn(input int i, input logic [7:0] d);
    m_ready = 1'b1; m_data_in = d; req_start[i] = 1'b0; #1;
    chk("req_ready", req_ready, 32'd1 << i);
    chk("req_data_in", req_data_in, d);
    cyc(); #1;
    chk("release_m_start", m_start, 0);
    chk("release_ready", req_ready, 32'd1 << i);
    chk("release_grant_held", grant_valid, 1);
    m_ready = 1'b0;
    cyc(); #1;
    chk("released", grant_valid, 0);
  endtask

  initial begin
    #2 reset = 1'b0; #1;
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_m_start", m_start, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_req_error", req_error, 0);
    cyc(); cyc();
    reset = 1'b1;

    // Single read request from requester 2
    cyc();
    req_start[2] = 1'b1; req_is_read[2] = 1'b1; req_register_address[32 +: 16] = 16'h0400; #1;
    chk("t1_no_grant_yet", grant_valid, 0);
    expect_grant(2);
    chk("t1_addr", m_register_address, 16'h0400);
    chk("t1_is_read", m_is_read, 1);
    finish_txn(2, 8'h5A);

    // All four together from reset: order 0,1,2,3
    reset = 1'b0; cyc(); reset = 1'b1;
    req_start = 4'hF;
    for (int i = 0; i < 4; i++) begin
      expect_grant(i);
      finish_txn(i, 8'(8'h10 + i));
    end

    // Burst lock: req1 holds grant over three bytes while req0 waits
    req_start[1] = 1'b1; req_nb_of_bytes[1] = 1'b1; req_is_read[1] = 1'b0;
    req_register_address[16 +: 16] = 16'h1234; req_i2c_data[8 +: 8] = 8'hA5;
    expect_grant(1);
    chk("t3_addr", m_register_address, 16'h1234);
    chk("t3_wdata", m_i2c_data, 8'hA5);
    chk("t3_nb", m_nb_of_bytes, 1);
    req_start[0] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      m_ready = 1'b1; req_start[1] = 1'b0; #1;
      chk("t3_byte_ready", req_ready, 4'b0010);
      cyc(); #1;
      chk("t3_lock_idx", grant_idx, 1);
      chk("t3_lock_busy", m_nb_of_bytes, 1);
      m_ready = 1'b0; req_start[1] = 1'b1;
      cyc();
    end
    req_nb_of_bytes[1] = 1'b0;
    finish_txn(1, 8'h33);
    expect_grant(0);
    finish_txn(0, 8'h44);

    // Fairness: req0 re-requests at once, req3 waiting goes first
    req_start[0] = 1'b1;
    expect_grant(0);
    req_start[3] = 1'b1;
    finish_txn(0, 8'h01);
    req_start[0] = 1'b1;
    expect_grant(3);
    finish_txn(3, 8'h02);
    expect_grant(0);
    finish_txn(0, 8'h03);

    // Watchdog: req2 granted, master never answers
    req_start[2] = 1'b1;
    expect_grant(2);
    for (int k = 1; k < 16; k++) begin
      cyc(); #1;
      chk("t5_no_err_early", req_error, 0);
    end
    chk("t5_start_before_timeout", m_start, 1);
    cyc(); #1;
    chk("t5_err_pulse", req_error, 4'b0100);
    chk("t5_m_start_forced", m_start, 0);
    chk("t5_grant_held", grant_valid, 1);
    req_start[2] = 1'b0;
    cyc(); #1;
    chk("t5_err_one_cycle", req_error, 0);
    chk("t5_idle", grant_valid, 0);

    // Asynchronous reset while BUSY
    req_start[3] = 1'b1;
    expect_grant(3);
    m_ready = 1'b1; #1;
    chk("t6_ready_pre", req_ready, 4'b1000);
    reset = 1'b0; #1;
    chk("t6_m_start", m_start, 0);
    chk("t6_grant_valid", grant_valid, 0);
    chk("t6_req_ready", req_ready, 0);
    cyc(); cyc();
    m_ready = 1'b0; req_start = 4'b1001; reset = 1'b1;
    expect_grant(0);
    finish_txn(0, 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
